byte_bus_master: RTL and testbench

BYTE_BUS_MASTER -- requirements
Module: byte_bus_master

---
 rtl/byte_bus_master_pkg.sv | 9 +
 rtl/byte_bus_master_if.sv | 11 +
 rtl/bus_watchdog.sv | 15 +
 rtl/byte_bus_master.sv | 116 +++++++++++
 tb/tb_byte_bus_master.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_bus_master_pkg.sv
// byte_bus_master_pkg: shared bus FSM states, size encodings and defaults
package byte_bus_master_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, GAP, FINISH} stateT;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} sizeT;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
  function automatic logic [1:0] lastByte(sizeT s);
    return s == SZ_WORD ? 2'd3 : s == SZ_HALF ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/byte_bus_master_if.sv
// byte_bus_master_if: byte-wide memory bus between master and slave
interface byte_bus_master_if #(parameter int DATA_WIDTH = 8, parameter int ADDRESS_WIDTH = 32) ();
  logic readMem;
  logic writemem;
  logic [ADDRESS_WIDTH-1:0] addressBus;
  logic [DATA_WIDTH-1:0] dataBusIn;
  logic memDataReady;
  logic [DATA_WIDTH-1:0] dataBusOut;
  modport master (output readMem, writemem, addressBus, dataBusIn, input memDataReady, dataBusOut);
  modport slave (input readMem, writemem, addressBus, dataBusIn, output memDataReady, dataBusOut);
endinterface

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts ready-wait cycles and flags the last allowed one
module bus_watchdog #(parameter int LIMIT = 1024) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [$clog2(LIMIT+1)-1:0] cnt;
  // count wait cycles; held at zero whenever the master is not in a byte access
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign expired = enable && cnt == $bits(cnt)'(LIMIT - 1);
endmodule

// File: rtl/byte_bus_master.sv
// byte_bus_master: splits CPU byte/half/word accesses into sequential bus byte transfers
module byte_bus_master
  import byte_bus_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic we,
  input  logic [1:0] size,
  input  logic sign_ext,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [4*DATA_WIDTH-1:0] wdata,
  output logic busy,
  output logic done,
  output logic error,
  output logic [4*DATA_WIDTH-1:0] rdata,
  byte_bus_master_if.master bus
);
  stateT state;
  sizeT szR;
  logic weR, sxR, expired, fill;
  logic [1:0] idx, last, nxt;
  logic [ADDRESS_WIDTH-1:0] addrR;
  logic [4*DATA_WIDTH-1:0] wdR, lane, loadValue;
  assign nxt = idx + 2'd1;
  bus_watchdog #(.LIMIT(TIMEOUT_CYCLES)) watchdog (
    .clk(clk),
    .rst(rst),
    .clear(state != ACCESS),
    .enable(state == ACCESS && !bus.memDataReady),
    .expired(expired)
  );
  // extend the collected load bytes from the top loaded byte
  always_comb begin
    fill = sxR & (szR == SZ_BYTE ? lane[DATA_WIDTH-1] : szR == SZ_HALF ? lane[2*DATA_WIDTH-1] : lane[4*DATA_WIDTH-1]);
    loadValue = szR == SZ_BYTE ? {{3*DATA_WIDTH{fill}}, lane[DATA_WIDTH-1:0]}
              : szR == SZ_HALF ? {{2*DATA_WIDTH{fill}}, lane[2*DATA_WIDTH-1:0]} : lane;
  end
  // access sequencer: one byte per ACCESS, one idle GAP between bytes, FINISH reports
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      rdata <= '0;
      bus.readMem <= 1'b0;
      bus.writemem <= 1'b0;
      bus.addressBus <= '0;
      bus.dataBusIn <= '0;
      idx <= '0;
      last <= '0;
      szR <= SZ_BYTE;
      weR <= 1'b0;
      sxR <= 1'b0;
      addrR <= '0;
      wdR <= '0;
      lane <= '0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (size == SZ_RSVD) error <= 1'b1;
          else begin
            state <= ACCESS;
            busy <= 1'b1;
            szR <= sizeT'(size);
            weR <= we;
            sxR <= sign_ext;
            addrR <= addr;
            wdR <= wdata;
            idx <= '0;
            last <= lastByte(sizeT'(size));
            lane <= '0;
            bus.readMem <= !we;
            bus.writemem <= we;
            bus.addressBus <= addr;
            bus.dataBusIn <= we ? wdata[DATA_WIDTH-1:0] : '0;
          end
        end
        ACCESS: if (bus.memDataReady) begin
          bus.readMem <= 1'b0;
          bus.writemem <= 1'b0;
          bus.dataBusIn <= '0;
          if (!weR) lane[idx*DATA_WIDTH +: DATA_WIDTH] <= bus.dataBusOut;
          state <= idx == last ? FINISH : GAP;
        end else if (expired) begin
          bus.readMem <= 1'b0;
          bus.writemem <= 1'b0;
          bus.dataBusIn <= '0;
          error <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        GAP: begin
          state <= ACCESS;
          idx <= nxt;
          bus.readMem <= !weR;
          bus.writemem <= weR;
          bus.addressBus <= addrR + ADDRESS_WIDTH'(nxt);
          bus.dataBusIn <= weR ? wdR[nxt*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        FINISH: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          if (!weR) rdata <= loadValue;
        end
      endcase
    end
endmodule

// File: tb/tb_byte_bus_master.sv
// tb_byte_bus_master: directed and randomized checks against a behavioural bus model
module tb_byte_bus_master;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic busy, done, error;
  logic [31:0] rdata;
  byte_bus_master_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(32)) bus ();
  byte_bus_master dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error), .rdata(rdata),
    .bus(bus.master)
  );
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int delay = 0, waited = 0, gapErr = 0, idleErr = 0, stabErr = 0;
  bit noise = 1'b0, prevHs = 1'b0, prevStrobe = 1'b0;
  logic [31:0] base = '0, prevAddr = '0, expRdata = '0;
  logic [7:0] prevData = '0;
  logic [7:0] rdBytes [4];
  logic [31:0] logAddr [$];
  logic [7:0] logData [$];
  logic logWe [$];
  int edges;
  bit gotDone, gotErr, busyStart;

  // slave: ready after `delay` wait cycles, read data by byte offset, protocol monitors
  initial forever begin
    logic strobe;
    logic [31:0] off;
    @(negedge clk);
    strobe = bus.readMem | bus.writemem;
    if (strobe && prevHs) gapErr++;
    if (!strobe && bus.dataBusIn !== 8'h00) idleErr++;
    if (bus.readMem && bus.writemem) idleErr++;
    if (strobe && prevStrobe && !prevHs && (bus.addressBus !== prevAddr || bus.dataBusIn !== prevData)) stabErr++;
    prevHs = 1'b0;
    prevStrobe = strobe;
    prevAddr = bus.addressBus;
    prevData = bus.dataBusIn;
    if (strobe) begin
      off = bus.addressBus - base;
      bus.dataBusOut = rdBytes[off[1:0]];
      if (waited >= delay) bus.memDataReady = 1'b1;
      else begin
        bus.memDataReady = 1'b0;
        waited++;
      end
    end else begin
      waited = 0;
      bus.memDataReady = noise ? 1'($urandom) : 1'b0;
      bus.dataBusOut = noise ? 8'($urandom) : 8'h00;
    end
  end

  // record every completed byte handshake
  initial forever begin
    @(posedge clk);
    if ((bus.readMem | bus.writemem) && bus.memDataReady) begin
      logAddr.push_back(bus.addressBus);
      logData.push_back(bus.writemem ? bus.dataBusIn : bus.dataBusOut);
      logWe.push_back(bus.writemem);
      prevHs = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] loadModel(input int n, input logic sx);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(rdBytes[i]) << (8 * i));
    if (sx && rdBytes[n-1][7]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    logWe.delete();
  endtask

  task automatic checkResetOutputs(input string t);
    check({t, ".flags"}, 32'({busy, done, error, bus.readMem, bus.writemem}), 0);
    check({t, ".rdata"}, rdata, 0);
    check({t, ".addressBus"}, bus.addressBus, 0);
    check({t, ".dataBusIn"}, 32'(bus.dataBusIn), 0);
  endtask

  task automatic run(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                     input logic [31:0] wd, input int dly, input int budget);
    @(negedge clk);
    delay = dly;
    base = a;
    clearLog();
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    busyStart = busy;
    edges = 0;
    gotDone = done;
    gotErr = error;
    while (!gotDone && !gotErr && edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
      gotDone = done;
      gotErr = error;
    end
  endtask

  task automatic expectAccess(input string t, input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd, input int dly);
    int n;
    n = 1 << sz;
    run(w, sz, sx, a, wd, dly, 200);
    check({t, ".busyStart"}, 32'(busyStart), 1);
    check({t, ".done"}, 32'(gotDone), 1);
    check({t, ".err"}, 32'(gotErr), 0);
    check({t, ".latency"}, 32'(edges), 32'(n * (dly + 2)));
    check({t, ".busyEnd"}, 32'(busy), 0);
    check({t, ".bytes"}, 32'(logAddr.size()), 32'(n));
    for (int i = 0; i < n && i < logAddr.size(); i++) begin
      check({t, ".addr"}, logAddr[i], a + 32'(i));
      check({t, ".we"}, 32'(logWe[i]), 32'(w));
      check({t, ".data"}, 32'(logData[i]), 32'(w ? wd[8*i +: 8] : rdBytes[i]));
    end
    if (!w) begin
      expRdata = loadModel(n, sx);
      check({t, ".rdata"}, rdata, expRdata);
    end
    @(posedge clk);
    #1;
    check({t, ".pulse"}, 32'({done, error}), 0);
  endtask

  initial begin
    bit found, saw, strobeAtErr;
    int doneAt, errAt;
    for (int i = 0; i < 4; i++) rdBytes[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    rdBytes[0] = 8'h11; rdBytes[1] = 8'h22; rdBytes[2] = 8'h33; rdBytes[3] = 8'h44;
    expectAccess("wordLoad", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 2);
    check("wordLoad.value", rdata, 32'h4433_2211);

    expectAccess("wordStore", 1'b1, 2'b10, 1'b0, 32'h0010_0004, 32'hDEAD_BEEF, 0);

    rdBytes[0] = 8'h80;
    expectAccess("signedByte", 1'b0, 2'b00, 1'b1, 32'h0010_0003, 32'h0, 0);
    check("signedByte.value", rdata, 32'hFFFF_FF80);
    expectAccess("unsignedByte", 1'b0, 2'b00, 1'b0, 32'h0010_0003, 32'h0, 0);
    check("unsignedByte.value", rdata, 32'h0000_0080);

    run(1'b0, 2'b01, 1'b0, 32'h0020_0000, 32'h0, 1 << 30, 1100);
    check("timeout.err", 32'(gotErr), 1);
    check("timeout.done", 32'(gotDone), 0);
    check("timeout.cycles", 32'(edges), 1024);
    check("timeout.rdata", rdata, 32'h0000_0080);
    check("timeout.idle", 32'({busy, bus.readMem, bus.writemem}), 0);
    check("timeout.bytes", 32'(logAddr.size()), 0);
    @(posedge clk);
    #1;
    check("timeout.pulse", 32'(error), 0);
    delay = 0;

    @(negedge clk);
    delay = 1;
    base = 32'h0030_0000;
    clearLog();
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = base; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = logAddr.size() == 1 && bus.writemem;
    end
    check("midReset.reach", 32'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetOutputs("midReset");
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      saw = saw | done | error;
    end
    check("midReset.quiet", 32'(saw), 0);
    check("midReset.bytes", 32'(logAddr.size()), 1);
    for (int i = 0; i < 4; i++) rdBytes[i] = 8'($urandom);
    expectAccess("afterReset", 1'b0, 2'b10, 1'b1, 32'h0030_0100, 32'h0, 1);

    @(negedge clk);
    delay = 0;
    base = 32'h0040_0001;
    rdBytes[0] = 8'h5A;
    clearLog();
    req = 1'b1; we = 1'b0; size = 2'b00; sign_ext = 1'b1; addr = base;
    @(posedge clk);
    #1;
    size = 2'b11;
    doneAt = 0;
    errAt = 0;
    strobeAtErr = 1'b0;
    for (int k = 1; k <= 10 && errAt == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) doneAt = k;
      if (error) begin
        errAt = k;
        strobeAtErr = bus.readMem | bus.writemem;
      end
    end
    req = 1'b0;
    check("heldReq.doneAt", 32'(doneAt), 2);
    check("heldReq.errAt", 32'(errAt), 3);
    check("heldReq.strobe", 32'(strobeAtErr), 0);
    check("heldReq.rdata", rdata, 32'h0000_005A);
    repeat (3) @(posedge clk);
    #1;
    check("heldReq.bytes", 32'(logAddr.size()), 1);
    check("heldReq.busy", 32'(busy), 0);

    noise = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      a = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      for (int i = 0; i < 4; i++) rdBytes[i] = 8'($urandom);
      expectAccess("rand", 1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), a, $urandom, $urandom_range(0, 3));
    end
    noise = 1'b0;

    check("mon.gap", 32'(gapErr), 0);
    check("mon.idleBus", 32'(idleErr), 0);
    check("mon.stable", 32'(stabErr), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
